// File: rtl/breath_duty_gen.sv
// Breathing duty-cycle generator: ramps duty up, holds at peak, ramps down,
// holds at trough and repeats, with enable/pause control and update strobes.
module breath_duty_gen #(
  parameter int DUTY_W     = 8,
  parameter int PRESC      = 1000,
  parameter int STEP       = 1,
  parameter int HOLD_STEPS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              pause_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_vld_o,
  output logic [2:0]        state_o,
  output logic              cycle_done_o
);

  localparam int PRESC_W     = $clog2(PRESC);
  localparam int HOLD_W      = $clog2(HOLD_STEPS + 2);
  localparam int HOLD_LAST_I = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;

  localparam logic [DUTY_W-1:0]  MAX        = '1;
  localparam logic [DUTY_W-1:0]  STEP_V     = DUTY_W'(STEP);
  localparam logic [DUTY_W:0]    STEP_EXT   = (DUTY_W+1)'(STEP);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_LAST_I);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_e;

  state_e              state_q;
  logic [DUTY_W-1:0]   duty_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                vld_q;
  logic                done_q;

  logic                tick;
  logic                hold_end;
  logic [DUTY_W:0]     duty_sum;
  logic [DUTY_W-1:0]   duty_up_d;
  logic [DUTY_W-1:0]   duty_dn_d;

  assign tick     = (presc_q == PRESC_LAST);
  assign hold_end = (hold_q == HOLD_LAST);

  // One extra bit on the sum so a non-dividing STEP saturates at MAX instead of wrapping
  assign duty_sum  = {1'b0, duty_q} + STEP_EXT;
  assign duty_up_d = (duty_sum >= {1'b0, MAX}) ? MAX : duty_sum[DUTY_W-1:0];
  assign duty_dn_d = (duty_q > STEP_V) ? (duty_q - STEP_V) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        duty_q  <= '0;
        presc_q <= '0;
        hold_q  <= '0;
        if (en_i) begin
          state_q <= RAMP_UP;
        end
      end else if (!en_i) begin
        // Disable wins over pause and over a tick landing on the same edge
        state_q <= IDLE;
        duty_q  <= '0;
        presc_q <= '0;
        hold_q  <= '0;
      end else if (!pause_i) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          unique case (state_q)
            RAMP_UP: begin
              duty_q <= duty_up_d;
              vld_q  <= 1'b1;
              if (duty_up_d == MAX) begin
                state_q <= (HOLD_STEPS == 0) ? RAMP_DN : HOLD_HI;
              end
            end
            HOLD_HI: begin
              if (hold_end) begin
                hold_q  <= '0;
                state_q <= RAMP_DN;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
            RAMP_DN: begin
              duty_q <= duty_dn_d;
              vld_q  <= 1'b1;
              if (duty_dn_d == '0) begin
                if (HOLD_STEPS == 0) begin
                  state_q <= RAMP_UP;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= HOLD_LO;
                end
              end
            end
            HOLD_LO: begin
              if (hold_end) begin
                hold_q  <= '0;
                state_q <= RAMP_UP;
                done_q  <= 1'b1;
              end else begin
                hold_q <= hold_q + 1'b1;
              end
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign duty_o       = duty_q;
  assign duty_vld_o   = vld_q;
  assign state_o      = state_q;
  assign cycle_done_o = done_q;

endmodule

// File: tb/tb_breath_duty_gen.sv
// Randomized and directed bench for breath_duty_gen; three instances with different
// parameters are compared every cycle against a tick-indexed profile table.
module tb_breath_duty_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] enV;
  logic [2:0] pauseV;

  logic [3:0] dutyA, dutyB;
  logic [4:0] dutyC;
  logic [2:0] stateA, stateB, stateC;
  logic [2:0] vldV, doneV;

  breath_duty_gen #(.DUTY_W(4), .PRESC(4), .STEP(1), .HOLD_STEPS(2)) dutA (
    .clk(clk), .rst(rst), .en_i(enV[0]), .pause_i(pauseV[0]),
    .duty_o(dutyA), .duty_vld_o(vldV[0]), .state_o(stateA), .cycle_done_o(doneV[0]));

  breath_duty_gen #(.DUTY_W(4), .PRESC(4), .STEP(4), .HOLD_STEPS(0)) dutB (
    .clk(clk), .rst(rst), .en_i(enV[1]), .pause_i(pauseV[1]),
    .duty_o(dutyB), .duty_vld_o(vldV[1]), .state_o(stateB), .cycle_done_o(doneV[1]));

  breath_duty_gen #(.DUTY_W(5), .PRESC(2), .STEP(3), .HOLD_STEPS(1)) dutC (
    .clk(clk), .rst(rst), .en_i(enV[2]), .pause_i(pauseV[2]),
    .duty_o(dutyC), .duty_vld_o(vldV[2]), .state_o(stateC), .cycle_done_o(doneV[2]));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int clkCnt = 0;

  // Profile tables: one entry per tick of a full breathing cycle
  int tDuty[3][64];
  int tState[3][64];
  int tVld[3][64];
  int tDone[3][64];
  int tLen[3];
  int pPresc[3];
  int expPeriod[3];
  int expVld[3];

  int mActive[3], mPhase[3], mIdx[3];
  int mDuty[3], mState[3], mVld[3], mDone[3];

  int prevVld[3], prevDone[3], lastDone[3], vldCnt[3];
  bit trackHold = 1'b0;
  int holdHiRun = 0;
  int holdLoRun = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic buildTable(input int d, input int dw, input int presc, input int step, input int hold);
    int mx, n, k, v;
    mx = (1 << dw) - 1;
    n  = (mx + step - 1) / step;
    k  = 0;
    for (int i = 1; i <= n; i++) begin
      v = i * step;
      tDuty[d][k] = (v > mx) ? mx : v;
      tVld[d][k] = 1; tDone[d][k] = 0;
      tState[d][k] = (i < n) ? 1 : ((hold > 0) ? 2 : 3);
      k++;
    end
    for (int j = 1; j <= hold; j++) begin
      tDuty[d][k] = mx; tVld[d][k] = 0; tDone[d][k] = 0;
      tState[d][k] = (j < hold) ? 2 : 3;
      k++;
    end
    for (int i = 1; i <= n; i++) begin
      v = mx - i * step;
      tDuty[d][k] = (v < 0) ? 0 : v;
      tVld[d][k] = 1;
      tDone[d][k] = (i == n && hold == 0) ? 1 : 0;
      tState[d][k] = (i < n) ? 3 : ((hold > 0) ? 4 : 1);
      k++;
    end
    for (int j = 1; j <= hold; j++) begin
      tDuty[d][k] = 0; tVld[d][k] = 0;
      tDone[d][k] = (j == hold) ? 1 : 0;
      tState[d][k] = (j < hold) ? 4 : 1;
      k++;
    end
    tLen[d] = k;
    pPresc[d] = presc;
    expPeriod[d] = (2 * n + 2 * hold) * presc;
    expVld[d] = 2 * n;
  endtask

  task automatic modelIdle(input int d);
    mActive[d] = 0; mPhase[d] = 0; mIdx[d] = 0;
    mDuty[d] = 0; mState[d] = 0; mVld[d] = 0; mDone[d] = 0;
    prevVld[d] = 0; prevDone[d] = 0; lastDone[d] = -1; vldCnt[d] = 0;
  endtask

  task automatic modelStep(input int d, input bit en, input bit pause);
    if (mActive[d] == 0) begin
      mVld[d] = 0; mDone[d] = 0; mDuty[d] = 0;
      if (en) begin
        mActive[d] = 1; mPhase[d] = 0; mIdx[d] = 0; mState[d] = 1;
      end else begin
        mState[d] = 0;
      end
    end else if (!en) begin
      mActive[d] = 0; mState[d] = 0; mDuty[d] = 0; mVld[d] = 0; mDone[d] = 0;
    end else if (pause) begin
      mVld[d] = 0; mDone[d] = 0;
    end else begin
      mPhase[d]++;
      if (mPhase[d] == pPresc[d]) begin
        mPhase[d] = 0;
        mDuty[d]  = tDuty[d][mIdx[d]];
        mState[d] = tState[d][mIdx[d]];
        mVld[d]   = tVld[d][mIdx[d]];
        mDone[d]  = tDone[d][mIdx[d]];
        mIdx[d]   = (mIdx[d] + 1) % tLen[d];
      end else begin
        mVld[d] = 0; mDone[d] = 0;
      end
    end
  endtask

  function automatic int obsDuty(input int d);
    case (d)
      0: return int'(dutyA);
      1: return int'(dutyB);
      default: return int'(dutyC);
    endcase
  endfunction

  function automatic int obsState(input int d);
    case (d)
      0: return int'(stateA);
      1: return int'(stateB);
      default: return int'(stateC);
    endcase
  endfunction

  task automatic compareAll(input int d);
    checkOutput($sformatf("duty%0d", d), obsDuty(d), mDuty[d]);
    checkOutput($sformatf("state%0d", d), obsState(d), mState[d]);
    checkOutput($sformatf("vld%0d", d), int'(vldV[d]), mVld[d]);
    checkOutput($sformatf("done%0d", d), int'(doneV[d]), mDone[d]);
  endtask

  // Drive one clock of inputs, advance the models, then compare on the falling edge
  task automatic applyStimulus(input logic [2:0] en, input logic [2:0] pause);
    enV = en;
    pauseV = pause;
    for (int d = 0; d < 3; d++) modelStep(d, en[d], pause[d]);
    @(negedge clk);
    clkCnt++;
    for (int d = 0; d < 3; d++) begin
      compareAll(d);
      checkOutput($sformatf("vldWidth%0d", d), prevVld[d] & int'(vldV[d]), 0);
      checkOutput($sformatf("doneWidth%0d", d), prevDone[d] & int'(doneV[d]), 0);
      prevVld[d] = int'(vldV[d]);
      prevDone[d] = int'(doneV[d]);
      if (!en[d] || pause[d]) lastDone[d] = -1;
      vldCnt[d] += int'(vldV[d]);
      if (doneV[d]) begin
        if (lastDone[d] >= 0) begin
          checkOutput($sformatf("period%0d", d), clkCnt - lastDone[d], expPeriod[d]);
          checkOutput($sformatf("vldCount%0d", d), vldCnt[d], expVld[d]);
        end
        lastDone[d] = clkCnt;
        vldCnt[d] = 0;
      end
    end
    if (trackHold) begin
      if (stateA == 3'd2) holdHiRun++;
      else if (holdHiRun > 0) begin
        checkOutput("holdHiLen", holdHiRun, 2 * 4);
        holdHiRun = 0;
      end
      if (stateA == 3'd4) holdLoRun++;
      else if (holdLoRun > 0) begin
        checkOutput("holdLoLen", holdLoRun, 2 * 4);
        holdLoRun = 0;
      end
    end
  endtask

  task automatic waitModelA(input int st, input int duty, input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus(3'b111, 3'b000);
      n++;
    end while (!(mState[0] == st && mDuty[0] == duty) && n < budget);
    if (!(mState[0] == st && mDuty[0] == duty)) checkOutput("waitTimeout", n, -1);
  endtask

  task automatic measureRestart(input string tag);
    int n;
    applyStimulus(3'b111, 3'b000);
    n = 0;
    do begin
      applyStimulus(3'b111, 3'b000);
      n++;
    end while (!vldV[0] && n < 50);
    checkOutput({tag, "Lat"}, n, 4);
    checkOutput({tag, "Duty"}, int'(dutyA), 1);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    enV = 3'b000;
    pauseV = 3'b000;
    buildTable(0, 4, 4, 1, 2);
    buildTable(1, 4, 4, 4, 0);
    buildTable(2, 5, 2, 3, 1);
    for (int d = 0; d < 3; d++) modelIdle(d);

    @(negedge clk);
    for (int d = 0; d < 3; d++) compareAll(d);
    rst = 1'b1;
    applyStimulus(3'b000, 3'b000);
    applyStimulus(3'b000, 3'b000);

    $display("[TB] full cycles");
    trackHold = 1'b1;
    repeat (300) applyStimulus(3'b111, 3'b000);
    trackHold = 1'b0;

    $display("[TB] pause in RAMP_UP");
    applyStimulus(3'b110, 3'b000);
    waitModelA(1, 6, 100);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b111, 3'b001);
      checkOutput("pauseDuty", int'(dutyA), 6);
      checkOutput("pauseState", int'(stateA), 1);
      checkOutput("pauseVld", int'(vldV[0]), 0);
    end
    n = 10;
    do begin
      applyStimulus(3'b111, 3'b000);
      n++;
    end while (!vldV[0] && n < 60);
    checkOutput("pauseLat", n, 4 + 10);
    checkOutput("pauseNext", int'(dutyA), 7);

    $display("[TB] disable on HOLD_HI tick");
    n = 0;
    while (!(mState[0] == 2 && mPhase[0] == 3) && n < 400) begin
      applyStimulus(3'b111, 3'b000);
      n++;
    end
    checkOutput("holdTickReached", int'(mState[0] == 2 && mPhase[0] == 3), 1);
    applyStimulus(3'b110, 3'b000);
    checkOutput("disState", int'(stateA), 0);
    checkOutput("disDuty", int'(dutyA), 0);
    checkOutput("disVld", int'(vldV[0]), 0);
    checkOutput("disDone", int'(doneV[0]), 0);
    measureRestart("reEn");

    $display("[TB] async reset in RAMP_DN");
    waitModelA(3, 9, 400);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstDuty", int'(dutyA), 0);
    checkOutput("rstVld", int'(vldV[0]), 0);
    checkOutput("rstDone", int'(doneV[0]), 0);
    checkOutput("rstState", int'(stateA), 0);
    checkOutput("rstStateB", int'(stateB), 0);
    for (int d = 0; d < 3; d++) modelIdle(d);
    @(negedge clk);
    for (int d = 0; d < 3; d++) compareAll(d);
    rst = 1'b1;
    measureRestart("rstRel");

    $display("[TB] random en/pause stress");
    for (int i = 0; i < 10000; i++) begin
      logic [2:0] en, pause;
      for (int d = 0; d < 3; d++) begin
        en[d] = (($urandom % 32) != 0);
        pause[d] = (($urandom % 6) == 0);
      end
      applyStimulus(en, pause);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/breath_duty_gen.md
Name: breath_duty_gen

Overview:
- Upstream brightness-profile stage for the LED PWM driver.
- Generates a breathing duty-cycle waveform: ramp up, hold at peak, ramp down, hold at trough, repeat.
- Presents the current duty value with a one-cycle update strobe; the downstream PWM stage samples `duty_o` on `duty_vld_o`.
- Adds enable and pause control so the LED path can be started, frozen and stopped cleanly.

Parameters:
- DUTY_W, 8, width of duty value; full scale MAX = 2^DUTY_W-1.
- PRESC, 1000, clocks per duty step (tick period); must be >= 2.
- STEP, 1, duty increment/decrement per tick; must be >= 1 and <= MAX.
- HOLD_STEPS, 16, ticks spent in each hold state; 0 skips the hold states.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- en_i  input  1  run enable, level
- pause_i  input  1  freeze all counters, state and duty while high (ignored in IDLE)
- duty_o  output  DUTY_W  current duty value, registered
- duty_vld_o  output  1  one-clock pulse, same cycle `duty_o` takes a tick-updated value
- state_o  output  3  FSM state: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4
- cycle_done_o  output  1  one-clock pulse on HOLD_LO→RAMP_UP transition

Behaviour:
- Reset (rst=0, async) forces the following, all registered:
  - `duty_o`=0, `duty_vld_o`=0, `cycle_done_o`=0, `state_o`=IDLE;
  - prescaler=0, hold counter=0.
- **IDLE**
  - `duty_o` held at 0; prescaler held at 0.
  - `en_i`=1 sampled at edge N → RAMP_UP at edge N. Prescaler counts from 0 starting the next cycle.
- **Prescaler and tick**
  - Increments each clock when state≠IDLE and `pause_i`=0.
  - tick = (prescaler==PRESC-1); the prescaler wraps to 0 on tick.
  - First tick after enable lands at edge N+PRESC.
- **On each tick, by state:**
  - RAMP_UP: duty = min(duty+STEP, MAX). If the new duty==MAX, go to HOLD_HI (or RAMP_DN if HOLD_STEPS=0). `duty_vld_o`=1.
  - HOLD_HI: hold counter +1. When the counter reaches HOLD_STEPS, clear it and go to RAMP_DN. Duty unchanged, no `duty_vld_o`.
  - RAMP_DN: duty = max(duty-STEP, 0), with no unsigned underflow. If the new duty==0, go to HOLD_LO (or RAMP_UP if HOLD_STEPS=0). `duty_vld_o`=1.
  - HOLD_LO: same counting as HOLD_HI. On exit to RAMP_UP, pulse `cycle_done_o`. With HOLD_STEPS=0, `cycle_done_o` pulses on the RAMP_DN→RAMP_UP tick instead.
- **Saturation:** a STEP that does not divide MAX still lands exactly on MAX and on 0 (e.g. DUTY_W=4, STEP=4: 0,4,8,12,15,11,7,3,0).
- **Pause** (`pause_i`=1): prescaler, hold counter, state and duty all freeze; no ticks and no pulses. Resuming continues from the exact frozen prescaler value.
- **Disable**
  - `en_i`=0 in any non-IDLE state → next edge: IDLE, `duty_o`=0, prescaler=0, hold counter=0, no pulses.
  - `en_i`=0 takes priority over `pause_i` and over a coincident tick.
- **Re-enable** always restarts from RAMP_UP with duty 0.
- **Pulses:** `duty_vld_o` and `cycle_done_o` are never high for more than one consecutive clock.
- **Cycle period:** 2·ceil(MAX/STEP)+2·HOLD_STEPS ticks, i.e. that many × PRESC clocks.

Test Plan:
- Reset mid-run:
  - Stimulus: DUTY_W=4, PRESC=4, STEP=1, HOLD_STEPS=2; en_i=1; assert rst=0 asynchronously while duty=9 in RAMP_DN.
  - Required response: all outputs 0 and state IDLE immediately, without waiting for a clock edge. After release with en_i=1, the first `duty_vld_o` is 4 clocks later with duty=1.
- Full cycle (same params):
  - Duty sequence on `duty_vld_o`: 1..15, then 14..0.
  - HOLD_HI and HOLD_LO each last 8 clocks.
  - `cycle_done_o` pulses once per 136 clocks; `duty_vld_o` count per cycle = 30.
- Saturating step:
  - Stimulus: DUTY_W=4, STEP=4, HOLD_STEPS=0.
  - Required response: vld values 4,8,12,15,11,7,3,0; `cycle_done_o` on the tick producing 0; period 8 ticks = 32 clocks.
- Pause:
  - Stimulus: pause_i=1 for 10 clocks at duty=6 in RAMP_UP.
  - Required response: no pulses, `duty_o`=6 and state unchanged throughout. After release, the next vld (duty=7) arrives exactly 10 clocks later than in the unpaused run.
- Disable:
  - Stimulus: en_i=0 on the same edge as a tick in HOLD_HI.
  - Required response: next edge state=IDLE, duty=0, no `duty_vld_o`/`cycle_done_o`. Re-enable restarts at duty 1 after 4 clocks.
- Pulse width check:
  - Stimulus: PRESC=2 random en/pause stress over 10k clocks.
  - Required response: `duty_vld_o`/`cycle_done_o` never high on 2 consecutive clocks; duty always within 0..MAX.
